// File: rtl/bip_pkg.sv
// Shared types and widths for the BIP-I control unit.
package bip_pkg;

    localparam int unsigned BIP_DATA_W = 16;
    localparam int unsigned BIP_ADDR_W = 11;
    localparam int unsigned BIP_OPC_W  = 5;

    typedef enum logic [BIP_OPC_W-1:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    imem_rd;
        logic    dmem_rd;
        logic    dmem_wr;
        logic    src_sel;
        alu_op_e alu_op;
        logic    wracc;
        logic    halted;
        logic    illegal;
    } strobe_t;

    // ALU operation implied by an accumulator-writing opcode.
    function automatic alu_op_e op_alu(input logic [BIP_OPC_W-1:0] opc);
        case (opc)
            OP_ADD, OP_ADDI: op_alu = ALU_ADD;
            OP_SUB, OP_SUBI: op_alu = ALU_SUB;
            default:         op_alu = ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational strobe decode from FSM state and the IR opcode.
module bip_decoder
    import bip_pkg::*;
(
    input  state_e                 state_i,
    input  logic [BIP_OPC_W-1:0]   opc_i,
    output strobe_t                strb_c_o
);

    always_comb begin
        strb_c_o = '0;
        case (state_i)
            ST_FETCH: strb_c_o.imem_rd = 1'b1;
            ST_EXEC: begin
                case (opc_i)
                    OP_LDI, OP_ADDI, OP_SUBI: begin
                        strb_c_o.src_sel = 1'b1;
                        strb_c_o.alu_op  = op_alu(opc_i);
                        strb_c_o.wracc   = 1'b1;
                    end
                    OP_STO:              strb_c_o.dmem_wr = 1'b1;
                    OP_LD, OP_ADD, OP_SUB: strb_c_o.dmem_rd = 1'b1;
                    OP_HLT:              ;
                    default:             strb_c_o.illegal = 1'b1;
                endcase
            end
            // Memory operand arrives this cycle; ALU B comes from dmem.
            ST_MEM: begin
                strb_c_o.alu_op = op_alu(opc_i);
                strb_c_o.wracc  = 1'b1;
            end
            ST_HALT:  strb_c_o.halted = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/bip_ctrl.sv
// BIP-I multi-cycle control unit: PC, IR and sequencing FSM.
module bip_ctrl
    import bip_pkg::*;
#(
    parameter int unsigned DATA_W = BIP_DATA_W,
    parameter int unsigned ADDR_W = BIP_ADDR_W,
    parameter int unsigned OPC_W  = BIP_OPC_W,
    parameter int unsigned RST_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              imem_rd_o,
    input  logic [DATA_W-1:0] instr_i,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic              dmem_rd_o,
    output logic              dmem_wr_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              src_sel_o,
    output logic [1:0]        alu_op_o,
    output logic              wracc_o,
    output logic              halted_o,
    output logic              illegal_o
);

    localparam logic [ADDR_W-1:0] RST_PC_V = ADDR_W'(RST_PC);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [OPC_W-1:0]   opc;
    strobe_t            strb;

    assign opc = ir_q[DATA_W-1 -: OPC_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
            pc_q    <= RST_PC_V;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state sequencing; the PC wraps naturally at 2^ADDR_W.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = instr_i;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opc)
                    OP_HLT:                state_d = ST_HALT;
                    OP_LD, OP_ADD, OP_SUB: state_d = ST_MEM;
                    default:               state_d = ST_FETCH;
                endcase
            end
            ST_MEM:    state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    bip_decoder u_dec (
        .state_i  (state_q),
        .opc_i    (opc),
        .strb_c_o (strb)
    );

    assign imem_addr_o = pc_q;
    assign dmem_addr_o = ir_q[ADDR_W-1:0];
    assign imm_o       = {{(DATA_W-ADDR_W){ir_q[ADDR_W-1]}}, ir_q[ADDR_W-1:0]};
    assign imem_rd_o   = strb.imem_rd;
    assign dmem_rd_o   = strb.dmem_rd;
    assign dmem_wr_o   = strb.dmem_wr;
    assign src_sel_o   = strb.src_sel;
    assign alu_op_o    = strb.alu_op;
    assign wracc_o     = strb.wracc;
    assign halted_o    = strb.halted;
    assign illegal_o   = strb.illegal;

endmodule
